act_stage_arbiter: RTL

- Shares one 16-lane, 1-cycle-latency ReLU activation unit among NUM_REQ upstream layer engines (conv/FC outputs).
- Round-robin burst arbitration; a grant is held for a whole burst (until the requester's last beat).
- Drives the unit's valid_in/input_data, tracks in-flight beats itself and buffers results in a 2-entry output FIFO with backpressure. The unit's valid_out is sticky (stays high after the first beat) and the unit cannot stall, so neither is used for flow control.

---
 rtl/act_stage_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/act_stage_arbiter.sv
// Round-robin burst arbiter in front of a shared 1-cycle ReLU unit.
// In-flight beats are tracked locally and results land in a 2-entry FWFT FIFO.
module act_stage_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int LANES   = 16,
    parameter int DW      = 16,
    parameter int IDW     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*LANES*DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        relu_valid_in,
    output logic [LANES*DW-1:0]         relu_data_in,
    input  logic [LANES*DW-1:0]         relu_data_out,
    output logic                        m_valid,
    output logic [LANES*DW-1:0]         m_data,
    output logic [IDW-1:0]              m_id,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic [IDW-1:0]              grant_id,
    output logic                        busy
);
    localparam int BW = LANES * DW;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   w_grant_nxt;
    logic [IDW-1:0]   r_rr;
    logic [IDW-1:0]   w_rr_nxt;
    logic [IDW-1:0]   w_pick;
    logic             w_pick_vld;
    int               w_best;

    logic [BW-1:0]    w_sel_data;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [BW-1:0]    r_hold_data;
    logic             w_space_ok;
    logic             w_accept;
    logic             w_pop;
    logic [2:0]       w_occ;

    logic             r_inflight;
    logic [IDW-1:0]   r_tag_id;
    logic             r_tag_last;

    logic [BW-1:0]    r_fifo_data [2];
    logic [IDW-1:0]   r_fifo_id   [2];
    logic             r_fifo_last [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    function automatic int rr_dist(input int r, input int base);
        return (r >= base) ? (r - base) : (r + NUM_REQ - base);
    endfunction

    // Pick the valid requester with the smallest distance at/after the rr pointer.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_best     = NUM_REQ;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (req_valid[r] && (rr_dist(r, int'(r_rr)) < w_best)) begin
                w_best     = rr_dist(r, int'(r_rr));
                w_pick     = IDW'(r);
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (r_grant == IDW'(r)) begin
                w_sel_data  = req_data[r*BW +: BW];
                w_sel_valid = req_valid[r];
                w_sel_last  = req_last[r];
            end
        end
    end

    // A pop in this cycle frees a slot immediately, which sustains 1 beat/cycle.
    assign w_pop      = m_valid & m_ready;
    assign w_occ      = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_space_ok = (w_occ < 3'd2);

    always_comb begin
        req_ready = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_ready[r] = (r_state == S_STREAM) && (r_grant == IDW'(r)) && w_space_ok;
        end
    end

    assign w_accept      = (r_state == S_STREAM) && w_sel_valid && w_space_ok;
    assign relu_valid_in = w_accept;
    assign relu_data_in  = w_accept ? w_sel_data : r_hold_data;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_accept && w_sel_last) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr        <= '0;
            r_inflight  <= 1'b0;
            r_hold_data <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr       <= w_rr_nxt;
            r_inflight <= w_accept;
            if (w_accept) begin
                r_hold_data <= w_sel_data;
            end
            if (r_inflight) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
        end
    end

    // Tag and FIFO payload need no reset; validity comes from r_inflight / r_count.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_id   <= r_grant;
            r_tag_last <= w_sel_last;
        end
        if (r_inflight) begin
            r_fifo_data[r_wr_ptr] <= relu_data_out;
            r_fifo_id[r_wr_ptr]   <= r_tag_id;
            r_fifo_last[r_wr_ptr] <= r_tag_last;
        end
    end

    assign m_valid  = (r_count != 2'd0);
    assign m_data   = m_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign m_id     = m_valid ? r_fifo_id[r_rd_ptr] : '0;
    assign m_last   = m_valid & r_fifo_last[r_rd_ptr];
    assign grant_id = r_grant;
    assign busy     = (r_state != S_IDLE) | r_inflight | m_valid;

endmodule
